// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Purpose  : Shared definitions for the TMDS receive decoder. Holds the four
//            control-token codes, the control-token match helpers, the
//            10b->8b data decode function, the per-channel state encoding and
//            a helper that sizes counters from their terminal counts.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  // Control tokens as they appear on the wire (bit 9 .. bit 0).
  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chan_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] c;       // {c1, c0}
  } ctrl_match_t;

  // Bits needed to hold any value 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic ctrl_match_t match_ctrl(input logic [9:0] w);
    ctrl_match_t m;
    m.valid = 1'b1;
    m.c     = 2'b00;
    case (w)
      TOKEN_C00: m.c = 2'b00;
      TOKEN_C01: m.c = 2'b01;
      TOKEN_C10: m.c = 2'b10;
      TOKEN_C11: m.c = 2'b11;
      default:   m.valid = 1'b0;
    endcase
    return m;
  endfunction

  // Token detect only, for places that have no use for the c bits.
  function automatic logic is_ctrl_token(input logic [9:0] w);
    return (w == TOKEN_C00) || (w == TOKEN_C01) ||
           (w == TOKEN_C10) || (w == TOKEN_C11);
  endfunction

  // Undo transition minimisation: bit 9 flags inversion, bit 8 selects
  // XOR versus XNOR chaining.
  function automatic logic [7:0] decode_data(input logic [9:0] d);
    logic [7:0] x;
    logic [7:0] q;
    x    = d[9] ? ~d[7:0] : d[7:0];
    q[0] = x[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = d[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    end
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_rx_channel.sv
`default_nettype none
// ============================================================================
// Module   : tmds_rx_channel
// Purpose  : One TMDS lane: two-word history, bit-slip window select and the
//            SEARCH/LOCKED alignment state machine.
// Ports    : clk_25mhz  - pixel clock
//            reset      - synchronous, active-high
//            raw        - unaligned 10-bit word from the deserializer
//            window     - aligned 10-bit word at the current slip
//            is_ctrl    - window holds a control token
//            lock_next  - channel will be LOCKED after the coming edge
// Revision : 1.0 - initial release
// ============================================================================
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_DWELL = 16,
  parameter int LINE_TIMEOUT = 1024
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [9:0] raw,
  output logic [9:0] window,
  output logic       is_ctrl,
  output logic       lock_next
);

  localparam int RUN_W   = cnt_width(CTRL_RUN);
  localparam int DWELL_W = cnt_width(SEARCH_DWELL);
  localparam int TMO_W   = cnt_width(LINE_TIMEOUT);

  logic [9:0]         cur;
  logic [9:0]         prev;
  logic [19:0]        hist;
  logic [3:0]         slip;
  chan_state_t        state;
  logic [RUN_W-1:0]   run;
  logic [DWELL_W-1:0] dwell;
  logic [TMO_W-1:0]   tmo;

  logic run_done;
  logic dwell_done;
  logic tmo_done;

  // prev arrived first, so it occupies the low (earlier) bits.
  assign hist = {cur, prev};

  always_comb begin
    window = hist[9:0];
    for (int k = 1; k < 10; k++) begin
      if (slip == 4'(k)) window = hist[k +: 10];
    end
  end

  assign is_ctrl = is_ctrl_token(window);

  assign run_done   = is_ctrl && (run == RUN_W'(CTRL_RUN - 1));
  assign dwell_done = (dwell == DWELL_W'(SEARCH_DWELL - 1));
  assign tmo_done   = !is_ctrl && (tmo == TMO_W'(LINE_TIMEOUT - 1));

  // Exposed one edge early so the top can register lock and the matching
  // pixel on the same edge.
  assign lock_next = (state == SEARCH) ? run_done : !tmo_done;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      cur   <= '0;
      prev  <= '0;
      slip  <= '0;
      state <= SEARCH;
      run   <= '0;
      dwell <= '0;
      tmo   <= '0;
    end else begin
      cur  <= raw;
      prev <= cur;
      case (state)
        SEARCH: begin
          // Lock takes priority over a dwell expiry on the same cycle.
          if (run_done) begin
            state <= LOCKED;
            run   <= '0;
            dwell <= '0;
            tmo   <= '0;
          end else if (dwell_done) begin
            slip  <= (slip == 4'd9) ? 4'd0 : slip + 4'd1;
            run   <= '0;
            dwell <= '0;
          end else begin
            run   <= is_ctrl ? run + RUN_W'(1) : '0;
            dwell <= dwell + DWELL_W'(1);
          end
        end
        LOCKED: begin
          // Dropping lock keeps the slip: a brief outage usually means the
          // alignment is still right.
          if (tmo_done) begin
            state <= SEARCH;
            run   <= '0;
            dwell <= '0;
            tmo   <= '0;
          end else begin
            tmo <= is_ctrl ? '0 : tmo + TMO_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmds_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_rx_decoder
// Purpose  : Three-lane TMDS receiver. Each lane aligns itself independently;
//            this level decodes the aligned words, merges them into RGB
//            pixels plus sync/de, and flags lanes that disagree on de.
// Ports    : clk_25mhz  - pixel clock
//            reset      - synchronous, active-high
//            in_red     - raw red TMDS word, bit 0 received first
//            in_green   - raw green TMDS word
//            in_blue    - raw blue TMDS word
//            out_pixel  - {red, green, blue} decoded data
//            out_de     - data enable
//            out_hsync  - blue control bit c0
//            out_vsync  - blue control bit c1
//            out_locked - all three lanes locked
//            out_err    - one-cycle pulse on inter-lane de disagreement
// Revision : 1.0 - initial release
// ============================================================================
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_DWELL = 16,
  parameter int LINE_TIMEOUT = 1024
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [9:0]  in_red,
  input  logic [9:0]  in_green,
  input  logic [9:0]  in_blue,
  output logic [23:0] out_pixel,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_locked,
  output logic        out_err
);

  // Lane index: 0 = blue, 1 = green, 2 = red.
  logic [9:0]  raw [3];
  logic [9:0]  win [3];
  logic [2:0]  is_ctrl;
  logic [2:0]  lock_next;

  logic        all_lock;
  logic        all_ctrl;
  logic        any_ctrl;
  ctrl_match_t blue_tok;
  logic [23:0] pixel_d;

  assign raw[0] = in_blue;
  assign raw[1] = in_green;
  assign raw[2] = in_red;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_chan
      tmds_rx_channel #(
        .CTRL_RUN     (CTRL_RUN),
        .SEARCH_DWELL (SEARCH_DWELL),
        .LINE_TIMEOUT (LINE_TIMEOUT)
      ) u_chan (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .raw       (raw[g]),
        .window    (win[g]),
        .is_ctrl   (is_ctrl[g]),
        .lock_next (lock_next[g])
      );
    end
  endgenerate

  assign all_lock = &lock_next;
  assign all_ctrl = &is_ctrl;
  assign any_ctrl = |is_ctrl;

  // Blue alone carries sync; red/green control bits are not used.
  always_comb begin
    blue_tok = match_ctrl(win[0]);
  end

  assign pixel_d = {decode_data(win[2]), decode_data(win[1]), decode_data(win[0])};

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      out_pixel  <= '0;
      out_de     <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_locked <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      out_locked <= all_lock;
      if (!all_lock) begin
        out_pixel <= '0;
        out_de    <= 1'b0;
        out_hsync <= 1'b0;
        out_vsync <= 1'b0;
        out_err   <= 1'b0;
      end else begin
        out_err <= any_ctrl && !all_ctrl;
        if (blue_tok.valid) begin
          out_pixel <= '0;
          out_de    <= 1'b0;
          out_hsync <= blue_tok.c[0];
          out_vsync <= blue_tok.c[1];
        end else begin
          // Sync levels persist through the active region.
          out_pixel <= pixel_d;
          out_de    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_rx_decoder
// Purpose  : Self-checking bench for tmds_rx_decoder: lock timing, bit-slip
//            search, token/data decode table, de disagreement, line timeout
//            and reset during search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_rx_decoder;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic [9:0]  in_red;
  logic [9:0]  in_green;
  logic [9:0]  in_blue;
  logic [23:0] out_pixel;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_locked;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0]  r;
    logic [9:0]  g;
    logic [9:0]  b;
    logic [23:0] pix;
    logic        de;
    logic        hs;
    logic        vs;
    logic        err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  tmds_rx_decoder dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .out_pixel  (out_pixel),
    .out_de     (out_de),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .out_locked (out_locked),
    .out_err    (out_err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic drive(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    in_red   = r;
    in_green = g;
    in_blue  = b;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pixel"}, out_pixel, 24'h0);
    check({tag, "_de"},    {23'h0, out_de},    24'h0);
    check({tag, "_hsync"}, {23'h0, out_hsync}, 24'h0);
    check({tag, "_vsync"}, {23'h0, out_vsync}, 24'h0);
    check({tag, "_err"},   {23'h0, out_err},   24'h0);
  endtask

  initial begin
    logic [9:0] tok;
    logic [9:0] blue_rot3;
    tok       = 10'h354;
    // Stream of 0x354 shifted by three bit times: token sits at hist[12:3].
    blue_rot3 = {tok[6:0], tok[9:7]};

    //          r        g        b        pixel      de    hs    vs    err
    vecs[0]  = '{10'h354, 10'h354, 10'h0AB, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{10'h354, 10'h354, 10'h2AB, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{10'h354, 10'h354, 10'h154, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{10'h200, 10'h100, 10'h100, 24'hFF0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{10'h200, 10'h200, 10'h200, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{10'h354, 10'h100, 10'h100, 24'hFD0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{10'h100, 10'h100, 10'h100, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{10'h354, 10'h354, 10'h354, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{10'h354, 10'h354, 10'h2AB, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{10'h100, 10'h200, 10'h200, 24'h00FFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{10'h354, 10'h354, 10'h0AB, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{10'h200, 10'h200, 10'h354, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{10'h354, 10'h354, 10'h354, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};

    // ---- reset state and lock at slip 0 ----
    reset = 1'b1;
    drive(10'h0, 10'h0, 10'h0);
    step(3);
    check("rst_locked", {23'h0, out_locked}, 24'h0);
    check_idle("rst");
    reset = 1'b0;
    drive(tok, tok, tok);
    step(9);
    check("lock0_early", {23'h0, out_locked}, 24'h0);
    step(1);
    check("lock0_rise", {23'h0, out_locked}, 24'h1);
    check_idle("lock0");

    // ---- blue offset by three bits: slip search ----
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    drive(tok, tok, blue_rot3);
    step(30);
    check("slip_mid", {23'h0, out_locked}, 24'h0);
    step(25);
    check("slip_early", {23'h0, out_locked}, 24'h0);
    step(1);
    check("slip_lock", {23'h0, out_locked}, 24'h1);

    // ---- relock aligned, then stream the decode table ----
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    drive(tok, tok, tok);
    step(10);
    check("tbl_locked", {23'h0, out_locked}, 24'h1);
    for (int c = 0; c < NVEC + 2; c++) begin
      if (c < NVEC) drive(vecs[c].r, vecs[c].g, vecs[c].b);
      else          drive(tok, tok, tok);
      step(1);
      if (c >= 2) begin
        check($sformatf("v%0d_pixel", c - 2), out_pixel, vecs[c-2].pix);
        check($sformatf("v%0d_de", c - 2),    {23'h0, out_de},    {23'h0, vecs[c-2].de});
        check($sformatf("v%0d_hsync", c - 2), {23'h0, out_hsync}, {23'h0, vecs[c-2].hs});
        check($sformatf("v%0d_vsync", c - 2), {23'h0, out_vsync}, {23'h0, vecs[c-2].vs});
        check($sformatf("v%0d_err", c - 2),   {23'h0, out_err},   {23'h0, vecs[c-2].err});
      end
    end
    step(4);
    check("tbl_still_locked", {23'h0, out_locked}, 24'h1);

    // ---- line timeout: 1024 data words drop lock ----
    drive(10'h100, 10'h100, 10'h100);
    step(1025);
    check("tmo_hold", {23'h0, out_locked}, 24'h1);
    check("tmo_hold_de", {23'h0, out_de}, 24'h1);
    step(1);
    check("tmo_drop", {23'h0, out_locked}, 24'h0);
    check_idle("tmo");

    // ---- reset in the middle of the following search ----
    step(20);
    reset = 1'b1;
    step(1);
    check("rst2_locked", {23'h0, out_locked}, 24'h0);
    reset = 1'b0;
    drive(tok, tok, tok);
    step(9);
    check("relock_early", {23'h0, out_locked}, 24'h0);
    step(1);
    check("relock_rise", {23'h0, out_locked}, 24'h1);
    check_idle("relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
